dct_coef_engine: RTL and testbench
==================================

DCT_COEF_ENGINE -- requirements
Module: dct_coef_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 N, 8, block side; power of two, 4..16.
 DATA_W, 8, unsigned pixel width.
 FRAC, 8, fraction bits of the internal 1-D cosine table.
REQ-002 Derived widths: LOGN = log2(N); OUT_W = DATA_W+2*LOGN+FRAC+3; ACC_W = OUT_W+FRAC.
REQ-003 Ports (name, direction, width, meaning), one per line:
 clk, in, 1, the single clock; all logic on rising edge.
 rst, in, 1, synchronous, active-high reset.
 start, in, 1, request a new coefficient computation.
 k1, in, LOGN, vertical frequency index; sampled on start acceptance.
 k2, in, LOGN, horizontal frequency index; sampled on start acceptance.
 start_ready, out, 1, engine idle and able to accept start.
 pix_valid, in, 1, pix_data valid.
 pix_data, in, DATA_W, unsigned pixel, row-major order (n1 outer, n2 inner).
 pix_ready, out, 1, engine accepts a pixel this cycle.
 coef_valid, out, 1, coef_data valid.
 coef_data, out, OUT_W, signed coefficient, FRAC fraction bits.
 coef_ready, in, 1, downstream accepts coef_data.

Function
REQ-004 Internal table C[k][n] = round(2^FRAC*cos(k*pi*(2n+1)/(2N))), signed FRAC+2 bits, for k,n in 0..N-1; generated at elaboration.
REQ-005 FSM states IDLE, ACCUM, OUT; transitions IDLE->ACCUM on start&&start_ready, ACCUM->OUT on acceptance of pixel N*N-1, OUT->IDLE on coef_valid&&coef_ready.
REQ-006 start_ready = 1 only in IDLE; start in other states is ignored.
REQ-007 On start acceptance: latch k1,k2; clear accumulator and n1,n2 counters to 0.
REQ-008 pix_ready = 1 only in ACCUM; a pixel is accepted when pix_valid&&pix_ready.
REQ-009 Per accepted pixel p at (n1,n2): acc += p' * C[k1][n1] * C[k2][n2], full-precision signed (2*FRAC fraction bits); p' per REQ-016.
REQ-010 Counters: n2 increments per accepted pixel and wraps N-1->0, n1 incrementing on each n2 wrap; the pixel at (N-1,N-1) ends ACCUM.
REQ-011 pix_valid low in ACCUM: stall, no state change; no timeout.
REQ-012 Entering OUT: coef_data = acc >>> FRAC (arithmetic, floor); coef_valid = 1 in the cycle after the last pixel is accepted.
REQ-013 In OUT, coef_data and coef_valid are held stable until coef_ready; coef_valid drops the cycle after the handshake.
REQ-014 No pixel is accepted outside ACCUM; pix_valid in IDLE/OUT is ignored and the pixel is not consumed.

Reset
REQ-015 rst (synchronous) forces IDLE, start_ready=1, pix_ready=0, coef_valid=0, coef_data=0, accumulator/counters/latched k cleared; any partial block is discarded, including when rst is asserted mid-ACCUM or in OUT.

Configuration
REQ-016 Macro DCT_LEVEL_SHIFT_EN: when defined, p' = pix_data - 2^(DATA_W-1) (signed, DATA_W+1 bits, JPEG level shift); when undefined, p' = zero-extended pix_data. No other behaviour differs.

Verification (N=8, DATA_W=8, FRAC=8)
REQ-017 Shift off, k=(0,0), 64 pixels of 1 -> coef_data=16384, coef_valid asserted 1 cycle after the 64th pixel.
REQ-018 Shift off, k=(6,4), pixel(0,0)=100, rest 0 -> 98*181*100>>>8 = 6928.
REQ-019 Shift off, k=(6,4), 64 pixels of 1 -> coef_data=0 (C[6] row sums to zero).
REQ-020 Shift on, k=(0,0), 64 pixels of 128 -> coef_data=0; 64 pixels of 129 -> 16384.
REQ-021 Backpressure: coef_ready low 5 cycles in OUT -> coef_data stable, pix_ready=0, start_ready=0, a start pulse is ignored; handshake -> IDLE next cycle.
REQ-022 Reset mid-op: rst after 20 pixels -> outputs at reset values; a following full block (shift off, k=(0,0), all 1) -> 16384.

Source files
------------

// File: rtl/dct_coef_engine.sv
// Single-coefficient 2-D DCT engine: it streams one NxN pixel block and accumulates p'*C[k1][n1]*C[k2][n2].
// Optional feature: define DCT_LEVEL_SHIFT_EN to subtract 2^(DATA_W-1) from each pixel (JPEG level shift).
module dct_coef_engine #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int FRAC   = 8,
    localparam int LOGN  = $clog2(N),
    localparam int OUT_W = DATA_W + 2 * LOGN + FRAC + 3,
    localparam int ACC_W = OUT_W + FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LOGN-1:0]   k1,
    input  logic [LOGN-1:0]   k2,
    output logic              start_ready,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              coef_valid,
    output logic [OUT_W-1:0]  coef_data,
    input  logic              coef_ready,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // each producer holds its valid and data stable until that edge.

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2} state_t;

    state_t state;
    logic [LOGN-1:0] k1_q, k2_q, n1, n2;
    logic signed [ACC_W-1:0] acc, acc_sum, term, pe, c1e, c2e;
    logic signed [DATA_W:0] pval;
    logic signed [FRAC+1:0] c1, c2;
    logic signed [FRAC+1:0] ctab [N][N];
    logic last;

    function automatic logic signed [FRAC+1:0] cos_entry(input int k, input int n);
        real ang;
        real v;
        int r;
        ang = 3.14159265358979323846 * real'(k * (2 * n + 1)) / real'(2 * N);
        v = $cos(ang) * real'(1 << FRAC);
        if (v >= 0.0)
            r = $rtoi(v + 0.5);
        else
            r = -$rtoi(0.5 - v);
        return r[FRAC+1:0];
    endfunction

    // Each entry is a localparam so the real-valued math only runs at elaboration.
    for (genvar gk = 0; gk < N; gk++) begin : g_row
        for (genvar gn = 0; gn < N; gn++) begin : g_col
            localparam logic signed [FRAC+1:0] CV = cos_entry(gk, gn);
            assign ctab[gk][gn] = CV;
        end
    end

    always_comb begin
`ifdef DCT_LEVEL_SHIFT_EN
        pval = {1'b0, pix_data} - {2'b01, {(DATA_W-1){1'b0}}};
`else
        pval = {1'b0, pix_data};
`endif
        c1      = ctab[k1_q][n1];
        c2      = ctab[k2_q][n2];
        pe      = {{(ACC_W-DATA_W-1){pval[DATA_W]}}, pval};
        c1e     = {{(ACC_W-FRAC-2){c1[FRAC+1]}}, c1};
        c2e     = {{(ACC_W-FRAC-2){c2[FRAC+1]}}, c2};
        term    = pe * c1e * c2e;
        acc_sum = acc + term;
        last    = (&n1) && (&n2);
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            pix_ready   <= 1'b0;
            coef_valid  <= 1'b0;
            coef_data   <= '0;
            acc         <= '0;
            n1          <= '0;
            n2          <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && start_ready) begin
                        k1_q        <= k1;
                        k2_q        <= k2;
                        acc         <= '0;
                        n1          <= '0;
                        n2          <= '0;
                        start_ready <= 1'b0;
                        pix_ready   <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (pix_valid && pix_ready) begin
                        acc <= acc_sum;
                        n2  <= n2 + 1'b1;
                        if (&n2)
                            n1 <= n1 + 1'b1;
                        if (last) begin
                            pix_ready  <= 1'b0;
                            coef_valid <= 1'b1;
                            // Slicing off the fraction bits of a signed value is a floor shift.
                            coef_data  <= acc_sum[ACC_W-1:FRAC];
                            state      <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (coef_valid && coef_ready) begin
                        coef_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coef_engine.sv
// Randomized bench for dct_coef_engine with a cosine-sum reference model and an expected-value queue.
// Honours DCT_LEVEL_SHIFT_EN the same way as the design build.
module tb_dct_coef_engine;

    localparam int N      = 8;
    localparam int DATA_W = 8;
    localparam int FRAC   = 8;
    localparam int LOGN   = 3;
    localparam int OUT_W  = DATA_W + 2 * LOGN + FRAC + 3;
    localparam int NPIX   = N * N;
    localparam real PI    = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LOGN-1:0]   k1, k2;
    logic              start_ready;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              coef_valid;
    logic [OUT_W-1:0]  coef_data;
    logic              coef_ready;
    logic [1:0]        state_dbg;

    int errors = 0;
    int checks = 0;
    logic [OUT_W-1:0] exp_q[$];
    int pix_mem[NPIX];

    dct_coef_engine #(.N(N), .DATA_W(DATA_W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .k1(k1), .k2(k2),
        .start_ready(start_ready), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .coef_valid(coef_valid), .coef_data(coef_data),
        .coef_ready(coef_ready), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] sx(input logic [OUT_W-1:0] v);
        return {{(64-OUT_W){v[OUT_W-1]}}, v};
    endfunction

    function automatic int cref(input int k, input int n);
        real v;
        v = $cos(PI * real'(2 * n + 1) * real'(k) / real'(2 * N)) * 256.0;
        return int'($floor(v + 0.5));
    endfunction

    // 2-D DCT basis sum over the stored block, then floor-divide by 2^FRAC.
    function automatic longint model(input int a, input int b);
        longint s;
        int p;
        s = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                p = pix_mem[r * N + c];
`ifdef DCT_LEVEL_SHIFT_EN
                p = p - (1 << (DATA_W - 1));
`endif
                s += longint'(p) * longint'(cref(a, r)) * longint'(cref(b, c));
            end
        return s >>> FRAC;
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < NPIX; i++) pix_mem[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = int'($urandom_range(255));
    endtask

    task automatic check_reset_vals();
        check("rst_start_ready", start_ready, 1);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_coef_data", sx(coef_data), 0);
    endtask

    task automatic run_block(input int a, input int b, input int ready_delay, input bit gaps,
                             input bit poke, input bit use_spec, input longint spec_val);
        logic [OUT_W-1:0] e;
        exp_q.push_back(OUT_W'(model(a, b)));
        check("start_ready_idle", start_ready, 1);
        start = 1'b1;
        k1 = LOGN'(a);
        k2 = LOGN'(b);
        @(posedge clk); #1;
        start = 1'b0;
        check("pix_ready_accum", pix_ready, 1);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    pix_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            pix_valid = 1'b1;
            pix_data = DATA_W'(pix_mem[i]);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        check("coef_latency", coef_valid, 1);
        check("pix_ready_out", pix_ready, 0);
        e = exp_q.pop_front();
        check("coef_data", sx(coef_data), sx(e));
        if (use_spec) check("coef_spec", sx(coef_data), spec_val);
        for (int d = 0; d < ready_delay; d++) begin
            if (poke && d == 1) begin
                start = 1'b1;
                k1 = LOGN'(a + 1);
                pix_valid = 1'b1;
                pix_data = 8'hAA;
            end
            @(posedge clk); #1;
            start = 1'b0;
            pix_valid = 1'b0;
            check("hold_coef_data", sx(coef_data), sx(e));
            check("hold_coef_valid", coef_valid, 1);
            check("hold_pix_ready", pix_ready, 0);
            check("hold_start_ready", start_ready, 0);
        end
        coef_ready = 1'b1;
        @(posedge clk); #1;
        coef_ready = 1'b0;
        check("coef_valid_drop", coef_valid, 0);
        check("start_ready_back", start_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        k1 = '0;
        k2 = '0;
        pix_valid = 1'b0;
        pix_data = '0;
        coef_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals();

`ifndef DCT_LEVEL_SHIFT_EN
        fill_const(1);
        run_block(0, 0, 0, 1'b0, 1'b0, 1'b1, 16384);
        fill_const(0);
        pix_mem[0] = 100;
        run_block(6, 4, 1, 1'b0, 1'b0, 1'b1, 6928);
        fill_const(1);
        run_block(6, 4, 0, 1'b0, 1'b0, 1'b1, 0);
`else
        fill_const(128);
        run_block(0, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        fill_const(129);
        run_block(0, 0, 1, 1'b0, 1'b0, 1'b1, 16384);
`endif
        fill_const(255);
        run_block(0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        fill_const(0);
        run_block(7, 7, 0, 1'b0, 1'b0, 1'b0, 0);

        // Output backpressure with a stray start and stray pixels while holding the coefficient.
        fill_rand();
        run_block(int'($urandom_range(N - 1)), int'($urandom_range(N - 1)), 5, 1'b1, 1'b1, 1'b0, 0);

        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_block(int'($urandom_range(N - 1)), int'($urandom_range(N - 1)),
                      int'($urandom_range(3)), 1'b1, 1'b0, 1'b0, 0);
        end

        // Abort a block after 20 pixels, then run a clean one.
        fill_rand();
        start = 1'b1;
        k1 = 3'd3;
        k2 = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_data = DATA_W'(pix_mem[i]);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals();
        fill_const(1);
`ifndef DCT_LEVEL_SHIFT_EN
        run_block(0, 0, 0, 1'b0, 1'b0, 1'b1, 16384);
`else
        run_block(0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
`endif

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
